// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants and next-PC select encodings for the fetch stage
package if_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSRC_PC4    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_J      = 2'b10,
    PCSRC_JR     = 2'b11
  } pc_src_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold and bubble controls
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // Bubble (or reset) beats load; with neither asserted the slot holds.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (reset || bubble_i) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end
  end

  // Slot register update.
  always_ff @(posedge clk) begin
    instr_q    <= instr_d;
    pc_plus4_q <= pc_plus4_d;
    valid_q    <= valid_d;
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC register, next-PC mux, IF/ID slot (option: BRANCH_DELAY_SLOT_EN)
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PC_src,
  input  logic [31:0] EX_branch_target,
  input  logic [31:0] ID_rs_data,
  input  logic        stall,
  output logic [31:0] IM_addr,
  input  logic [31:0] IM_data,
  output logic [31:0] IF_PC,
  output logic [31:0] ID_instruction,
  output logic [31:0] ID_PC_plus4,
  output logic        ID_valid,
  output logic        ID_EX_flush
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] j_target;
  logic        slot_load;
  logic        slot_bubble;

  assign pc_plus4 = pc_q + 32'd4;
  assign j_target = {ID_PC_plus4[31:28], ID_instruction[25:0], 2'b00};

  // Next-PC select and IF/ID control; priority reset > branch > stall > j/jr > PC+4.
  always_comb begin
    pc_d        = pc_q;
    slot_load   = 1'b0;
    slot_bubble = 1'b0;
    ID_EX_flush = 1'b0;
    if (reset) begin
      pc_d        = RESET_PC;
      slot_bubble = 1'b1;
    end else if (PC_src == PCSRC_BRANCH) begin
      pc_d        = EX_branch_target;
      slot_bubble = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
      ID_EX_flush = 1'b0;
`else
      ID_EX_flush = 1'b1;
`endif
    end else if (stall) begin
      pc_d = pc_q;
    end else if (PC_src == PCSRC_J || PC_src == PCSRC_JR) begin
      pc_d = (PC_src == PCSRC_J) ? j_target : ID_rs_data;
`ifdef BRANCH_DELAY_SLOT_EN
      slot_load   = 1'b1;
`else
      slot_bubble = 1'b1;
`endif
    end else begin
      pc_d      = pc_plus4;
      slot_load = 1'b1;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .load_i     (slot_load),
    .bubble_i   (slot_bubble),
    .instr_i    (IM_data),
    .pc_plus4_i (pc_plus4),
    .instr_o    (ID_instruction),
    .pc_plus4_o (ID_PC_plus4),
    .valid_o    (ID_valid)
  );

  assign IF_PC   = pc_q;
  assign IM_addr = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a transaction-level fetch model
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PC_src;
  logic [31:0] EX_branch_target;
  logic [31:0] ID_rs_data;
  logic        stall;
  logic [31:0] IM_addr;
  logic [31:0] IM_data;
  logic [31:0] IF_PC;
  logic [31:0] ID_instruction;
  logic [31:0] ID_PC_plus4;
  logic        ID_valid;
  logic        ID_EX_flush;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .PC_src           (PC_src),
    .EX_branch_target (EX_branch_target),
    .ID_rs_data       (ID_rs_data),
    .stall            (stall),
    .IM_addr          (IM_addr),
    .IM_data          (IM_data),
    .IF_PC            (IF_PC),
    .ID_instruction   (ID_instruction),
    .ID_PC_plus4      (ID_PC_plus4),
    .ID_valid         (ID_valid),
    .ID_EX_flush      (ID_EX_flush)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0040_0004)      return 32'h0800_0010;
    else if (a < 32'h0000_0100)  return 32'h2008_0001;
    else                         return 32'h8C00_0000 | {16'h0, a[15:0]};
  endfunction

  assign IM_data = imem(IM_addr);

  // Model state: what the fetch PC and IF/ID slot must hold after each edge.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_flush;
  logic [31:0] n_pc, n_instr, n_pc4;
  logic        n_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT versus model every cycle, mid-period.
  always @(negedge clk) begin
    if (check_en) begin
      chk("IF_PC", IF_PC, m_pc);
      chk("IM_addr", IM_addr, m_pc);
      chk("ID_instruction", ID_instruction, m_instr);
      chk("ID_PC_plus4", ID_PC_plus4, m_pc4);
      chk("ID_valid", {31'h0, ID_valid}, {31'h0, m_valid});
      chk("ID_EX_flush", {31'h0, ID_EX_flush}, {31'h0, m_flush});
    end
  end

  // Apply inputs for the coming edge and work out the model's next state.
  task automatic drive(input logic rst, input logic [1:0] src, input logic [31:0] tgt,
                       input logic [31:0] rs, input logic stl);
    reset = rst; PC_src = src; EX_branch_target = tgt; ID_rs_data = rs; stall = stl;
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; m_flush = 1'b0;
    if (rst) begin
      n_pc = 32'h0; n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
    end else if (src == 2'b01) begin
      n_pc = tgt; n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
      m_flush = !DS;
    end else if (stl) begin
      // everything holds
    end else if (src[1]) begin
      n_pc = (src == 2'b10) ? {m_pc4[31:28], m_instr[25:0], 2'b00} : rs;
      if (DS) begin
        n_instr = imem(m_pc); n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
      end else begin
        n_instr = 32'h0; n_pc4 = 32'h0; n_valid = 1'b0;
      end
    end else begin
      n_pc = m_pc + 32'd4; n_instr = imem(m_pc); n_pc4 = m_pc + 32'd4; n_valid = 1'b1;
    end
  endtask

  task automatic clock();
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid;
    check_en = 1'b1;
  endtask

  task automatic step(input logic rst, input logic [1:0] src, input logic [31:0] tgt,
                      input logic [31:0] rs, input logic stl);
    drive(rst, src, tgt, rs, stl);
    clock();
  endtask

  initial begin
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_flush = 1'b0;
    reset = 1'b1; PC_src = 2'b00; EX_branch_target = 32'h0; ID_rs_data = 32'h0; stall = 1'b0;
    @(posedge clk); #1;
    step(1, 2'b00, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0);
    chk("reset IF_PC", IF_PC, 32'h0);
    chk("reset ID_valid", {31'h0, ID_valid}, 32'h0);
    chk("reset ID_instruction", ID_instruction, 32'h0);

    // Free-running fetch from 0.
    step(0, 2'b00, 0, 0, 0);
    chk("run1 IF_PC", IF_PC, 32'h4);
    chk("run1 ID_PC_plus4", ID_PC_plus4, 32'h4);
    chk("run1 ID_instruction", ID_instruction, 32'h2008_0001);
    step(0, 2'b00, 0, 0, 0);
    chk("run2 IF_PC", IF_PC, 32'h8);
    chk("run2 ID_PC_plus4", ID_PC_plus4, 32'h8);

    // Two stalled cycles at 0x8, the second also requesting a jr that must be ignored.
    step(0, 2'b00, 0, 0, 1);
    step(0, 2'b11, 0, 32'h0000_0200, 1);
    chk("stall IF_PC", IF_PC, 32'h8);
    chk("stall ID_PC_plus4", ID_PC_plus4, 32'h8);
    chk("stall ID_valid", {31'h0, ID_valid}, 32'h1);
    step(0, 2'b00, 0, 0, 0);
    chk("resume IF_PC", IF_PC, 32'hC);
    chk("resume ID_PC_plus4", ID_PC_plus4, 32'hC);

    // jr to 0x00400004, fetch the j there, then take the j.
    step(0, 2'b11, 0, 32'h0040_0004, 0);
    chk("jr IF_PC", IF_PC, 32'h0040_0004);
    chk("jr ID_valid", {31'h0, ID_valid}, {31'h0, DS});
    step(0, 2'b00, 0, 0, 0);
    chk("jfetch ID_instruction", ID_instruction, 32'h0800_0010);
    chk("jfetch ID_PC_plus4", ID_PC_plus4, 32'h0040_0008);
    step(0, 2'b10, 0, 0, 0);
    chk("j IF_PC", IF_PC, 32'h0000_0040);
    chk("j ID_valid", {31'h0, ID_valid}, {31'h0, DS});
    step(0, 2'b00, 0, 0, 0);

    // Branch with a simultaneous stall: branch wins.
    drive(0, 2'b01, 32'h0000_0100, 0, 1);
    #1;
    chk("branch ID_EX_flush", {31'h0, ID_EX_flush}, {31'h0, !DS});
    clock();
    chk("branch IF_PC", IF_PC, 32'h100);
    chk("branch ID_valid", {31'h0, ID_valid}, 32'h0);
    chk("branch ID_instruction", ID_instruction, 32'h0);
    step(0, 2'b00, 0, 0, 0);

    // jr to the top of the address space, then wrap.
    step(0, 2'b11, 0, 32'hFFFF_FFFC, 0);
    chk("jrtop IF_PC", IF_PC, 32'hFFFF_FFFC);
    step(0, 2'b00, 0, 0, 0);
    chk("wrap IF_PC", IF_PC, 32'h0);
    chk("wrap ID_PC_plus4", ID_PC_plus4, 32'h0);
    chk("wrap ID_instruction", ID_instruction, 32'h8C00_FFFC);
    step(0, 2'b00, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0);

    // Reset while stalled and branching.
    step(0, 2'b00, 0, 0, 1);
    drive(1, 2'b01, 32'h0000_0300, 0, 1);
    #1;
    chk("rst ID_EX_flush", {31'h0, ID_EX_flush}, 32'h0);
    clock();
    chk("rst IF_PC", IF_PC, 32'h0);
    chk("rst ID_valid", {31'h0, ID_valid}, 32'h0);
    step(0, 2'b00, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0);
    chk("post IF_PC", IF_PC, 32'h8);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 PC_src  input  2  next-PC select from controller: 00 PC+4, 01 branch, 10 j, 11 jr.
REQ-004 EX_branch_target  input  32  taken-branch target computed in EX; used when PC_src=01.
REQ-005 ID_rs_data  input  32  forwarded rs value; jr target when PC_src=11.
REQ-006 stall  input  1  load-use stall from hazard unit; hold PC and IF/ID.
REQ-007 IM_addr  output  32  instruction-memory address, equal to IF_PC.
REQ-008 IM_data  input  32  instruction word, combinational read of IM_addr.
REQ-009 IF_PC  output  32  current fetch PC register.
REQ-010 ID_instruction  output  32  IF/ID instruction register, feeding the ID-stage controller.
REQ-011 ID_PC_plus4  output  32  IF/ID copy of fetch PC+4.
REQ-012 ID_valid  output  1  1 when ID_instruction is a real instruction, 0 for a bubble.
REQ-013 ID_EX_flush  output  1  combinational request to squash the ID/EX register.

Function
REQ-014 PC+4 and jump target SHALL use 32-bit modulo arithmetic; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-015 j target SHALL be {ID_PC_plus4[31:28], ID_instruction[25:0], 2'b00}.
REQ-016 jr target SHALL be ID_rs_data unmodified; no alignment check.
REQ-017 Priority each cycle: reset > branch (PC_src=01) > stall > j/jr (10/11) > PC+4.
REQ-018 Branch: PC <= EX_branch_target; IF/ID <= bubble; stall SHALL be ignored that cycle.
REQ-019 Stall without branch: PC, ID_instruction, ID_PC_plus4 and ID_valid SHALL hold; PC_src 10/11 SHALL be ignored.
REQ-020 j/jr without stall: PC <= target; IF/ID slot handling per REQ-026/027.
REQ-021 PC+4: PC <= PC+4; IF/ID <= {IM_data, PC+4, valid=1}.
REQ-022 Bubble SHALL be ID_instruction=32'h00000000, ID_PC_plus4=0, ID_valid=0.
REQ-023 Fetch-to-ID latency SHALL be exactly one cycle when no stall or redirect occurs.
REQ-024 IM_addr SHALL equal IF_PC combinationally, including while stalled.

Reset
REQ-025 While reset=1 at a clock edge: IF_PC <= RESET_PC (32'h00000000); IF/ID <= bubble; reset mid-stall or mid-redirect SHALL override all inputs; ID_EX_flush SHALL be 0 while reset is high.

Configuration
REQ-026 With BRANCH_DELAY_SLOT_EN defined: on j/jr the fetched instruction SHALL enter IF/ID as valid; on branch the ID instruction is the delay slot, IF/ID SHALL still be bubbled, and ID_EX_flush=0.
REQ-027 Without BRANCH_DELAY_SLOT_EN: on j/jr IF/ID SHALL be bubbled; on branch IF/ID SHALL be bubbled and ID_EX_flush=1 for that cycle; otherwise ID_EX_flush=0.

Structure
REQ-028 Shared package SHALL hold RESET_PC, NOP_INSTR, and PC_src encodings PCSRC_PC4/BRANCH/J/JR.
REQ-029 One sub-module SHALL be natural: if_id_reg (IF/ID register with load, hold and bubble controls); next-PC mux stays in if_stage.

Verification
REQ-030 Reset, then 3 free-running cycles with IM_data=0x20080001 -> IF_PC 0x0,0x4,0x8,0xC; ID_PC_plus4 0x4,0x8,0xC; ID_valid=1.
REQ-031 stall=1 for 2 cycles at IF_PC=0x8 -> IF_PC and ID_instruction held, then fetch resumes at 0x8 -> 0xC.
REQ-032 ID_instruction=0x08000010 (j) with ID_PC_plus4=0x00400008, PC_src=10 -> next IF_PC=0x00000040; ID_valid=0 without macro, 1 with macro.
REQ-033 PC_src=01, EX_branch_target=0x100, stall=1 same cycle -> IF_PC=0x100, bubble in IF/ID, ID_EX_flush=1 without macro, 0 with macro.
REQ-034 PC_src=11, ID_rs_data=0xFFFFFFFC, then free-running -> IF_PC 0xFFFFFFFC then 0x00000000.
REQ-035 reset asserted during stall with PC_src=01 -> IF_PC=0x0, ID_valid=0, ID_EX_flush=0.
